// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Parses a 2-byte little-endian word count N, then 4N payload bytes packed
// little-endian into 32-bit words, writing them to word addresses 0..N-1.
// Holds the processor in reset until the whole image has been written.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, 4 checksum bytes (word C) follow the payload and the image
//   is accepted only if sum(words) + C == 0 mod 2^32.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   source presents a byte on in_data
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte this cycle
//   we         out  instruction-memory write strobe (one cycle per word)
//   waddr      out  word address of the write
//   wdata      out  word to write
//   cpu_reset  out  processor reset, high until the load succeeds
//   done       out  image loaded (sticky until reset)
//   err        out  malformed image (sticky until reset)
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t        state_q, state_d;
    logic [7:0]    cnt_lo_q, cnt_lo_d;
    logic [AW-1:0] n_last_q, n_last_d;   // N-1: index of the final word
    logic [1:0]    idx_q, idx_d;         // byte position within the current word
    logic [23:0]   wbuf_q, wbuf_d;       // first three bytes of the current word
    logic [AW-1:0] wcnt_q, wcnt_d;       // address of the next write
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   acc_q, acc_d;
`endif

    logic          ready_c;
    logic          accept;
    logic [15:0]   n_hdr;
    logic [31:0]   word;
    logic [23:0]   wbuf_next;

    assign accept = in_valid & ready_c;
    assign n_hdr  = {in_data, cnt_lo_q};
    assign word   = {in_data, wbuf_q};

    // Byte lane placement shared by payload and checksum collection.
    always_comb begin
        wbuf_next = wbuf_q;
        case (idx_q)
            2'd0:    wbuf_next[7:0]   = in_data;
            2'd1:    wbuf_next[15:8]  = in_data;
            2'd2:    wbuf_next[23:16] = in_data;
            default: wbuf_next        = wbuf_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        n_last_d = n_last_q;
        idx_d    = idx_q;
        wbuf_d   = wbuf_q;
        wcnt_d   = wcnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        ready_c  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        case (state_q)
            S_HDR0: begin
                ready_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc_d   = '0;
`endif
                if (accept) begin
                    cnt_lo_d = in_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                ready_c = 1'b1;
                if (accept) begin
                    if (n_hdr == 16'd0 || n_hdr > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        n_last_d = AW'(n_hdr - 16'd1);
                        idx_d    = 2'd0;
                        wcnt_d   = '0;
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ready_c = 1'b1;
                if (accept) begin
                    idx_d  = idx_q + 2'd1;
                    wbuf_d = wbuf_next;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = wcnt_q;
                        wdata_d = word;
                        wcnt_d  = wcnt_q + AW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc_d   = acc_q + word;
                        if (wcnt_q == n_last_q) state_d = S_CSUM;
`else
                        if (wcnt_q == n_last_q) state_d = S_FLUSH;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                ready_c = 1'b1;
                if (accept) begin
                    idx_d  = idx_q + 2'd1;
                    wbuf_d = wbuf_next;
                    if (idx_q == 2'd3) begin
                        // Folding C into the sum leaves a plain zero test for FLUSH.
                        acc_d   = acc_q + word;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = (acc_q == 32'd0) ? S_DONE : S_ERR;
`else
            S_FLUSH: state_d = S_DONE;
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_HDR0;
            cnt_lo_q <= '0;
            n_last_q <= '0;
            idx_q    <= '0;
            wbuf_q   <= '0;
            wcnt_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            n_last_q <= n_last_d;
            idx_q    <= idx_d;
            wbuf_q   <= wbuf_d;
            wcnt_q   <= wcnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

    // The state register sits at HDR0 during reset, so ready is masked here.
    assign in_ready  = ready_c & ~reset;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign cpu_reset = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          cpu_reset;
    logic          done;
    logic          err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Write monitor: every strobe is logged with its cycle number.
    int            cyc = 0;
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int            obs_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!reset && we) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
            obs_cyc.push_back(cyc);
            check("cpu_reset_during_we", cpu_reset, 1);
        end
    end

    // Image under construction and the reference model's verdict on it.
    logic [7:0]  img[$];
    logic [31:0] exp_w[$];
    bit          exp_done;
    bit          exp_err;

    task automatic img_hdr(input int n);
        img = {};
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
    endtask

    task automatic img_word(input logic [31:0] w);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
    endtask

    // Random legal image; bad_csum corrupts the trailing checksum when present.
    task automatic build_random(input int n, input bit bad_csum);
        logic [31:0] sum = 32'd0;
        logic [31:0] w;
        img_hdr(n);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            sum += w;
            img_word(w);
        end
        if (CSUM_EN) img_word(32'd0 - sum + (bad_csum ? 32'd7 : 32'd0));
    endtask

    task automatic model();
        int n;
        logic [31:0] sum;
        logic [31:0] c;
        int base;
        n = int'({img[1], img[0]});
        exp_w = {};
        if (n == 0 || n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        sum = 32'd0;
        for (int k = 0; k < n; k++) begin
            base = 2 + 4 * k;
            exp_w.push_back({img[base+3], img[base+2], img[base+1], img[base]});
            sum += exp_w[k];
        end
        exp_done = 1'b1;
        if (CSUM_EN) begin
            base = 2 + 4 * n;
            c = {img[base+3], img[base+2], img[base+1], img[base]};
            exp_done = ((sum + c) == 32'd0);
        end
        exp_err = !exp_done;
    endtask

    task automatic send(input bit gaps, input int stall_at, output int lat, output bit ok);
        int t;
        lat = 0;
        ok  = 1'b1;
        for (int i = 0; i < img.size(); i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat (10) begin @(negedge clk); lat++; end
            end else if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) begin @(negedge clk); lat++; end
            end
            in_valid = 1'b1;
            in_data  = img[i];
            t = 0;
            while (!in_ready && t < 16) begin @(negedge clk); t++; lat++; end
            if (!in_ready) begin ok = 1'b0; break; end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        obs_addr = {};
        obs_data = {};
        obs_cyc  = {};
    endtask

    task automatic run_image(input string tag, input bit gaps, input int stall_at, input bit last_we_chk);
        int lat;
        bit ok;
        int t;
        int n;
        model();
        n = exp_w.size();
        send(gaps, stall_at, lat, ok);
        check({tag, "_accept"}, ok, 1);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (last_we_chk) begin
            check({tag, "_last_we"}, we, 1);
            check({tag, "_last_waddr"}, waddr, n - 1);
            check({tag, "_last_wdata"}, wdata, exp_w[n-1]);
            check({tag, "_done_early"}, done, 0);
        end
`endif
        t = 0;
        while (!(done || err) && t < 20) begin @(negedge clk); t++; lat++; end
        check({tag, "_end"}, done || err, 1);
        if (exp_done && !gaps && stall_at < 0)
            check({tag, "_latency"}, lat, 2 + 4 * n + 1 + (CSUM_EN ? 4 : 0));
        @(negedge clk);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_cpu_reset"}, cpu_reset, !exp_done);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_we_idle"}, we, 0);
        check({tag, "_nwrites"}, obs_addr.size(), n);
        for (int k = 0; k < n && k < obs_addr.size(); k++) begin
            check({tag, "_waddr"}, obs_addr[k], k);
            check({tag, "_wdata"}, obs_data[k], exp_w[k]);
            if (k > 0 && !gaps && stall_at < 0)
                check({tag, "_spacing"}, obs_cyc[k] - obs_cyc[k-1], 4);
        end
    endtask

    initial begin
        int bad;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // Single-word image from the example program.
        apply_reset();
        img_hdr(1);
        img_word(32'h0050_0513);
        if (CSUM_EN) img_word(32'd0 - 32'h0050_0513);
        run_image("n1", 1'b0, -1, 1'b1);

        // Three words at full rate.
        apply_reset();
        img_hdr(3);
        img_word(32'h1111_1111);
        img_word(32'h2222_2222);
        img_word(32'h3333_3333);
        if (CSUM_EN) img_word(32'd0 - 32'h6666_6666);
        run_image("n3", 1'b0, -1, 1'b0);

        // Illegal word counts.
        apply_reset();
        img_hdr(0);
        run_image("n0", 1'b0, -1, 1'b0);
        apply_reset();
        img_hdr(65);
        run_image("n65", 1'b0, -1, 1'b0);
        apply_reset();
        img_hdr(256);
        run_image("n256", 1'b0, -1, 1'b0);

        // Stalls, including a 10-cycle gap in the middle of word 0.
        apply_reset();
        build_random(2, 1'b0);
        run_image("n2_gaps", 1'b1, 4, 1'b0);

        // Largest legal image.
        apply_reset();
        build_random(DEPTH, 1'b0);
        run_image("n64", 1'b0, -1, 1'b0);

        // Abort after 5 payload bytes, then load a fresh image.
        apply_reset();
        build_random(2, 1'b0);
        img = img[0:6];
        begin
            int lat;
            bit ok;
            send(1'b0, -1, lat, ok);
            check("abort_accept", ok, 1);
        end
        reset = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_we", we, 0);
        check("abort_waddr", waddr, 0);
        check("abort_wdata", wdata, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        obs_addr = {};
        obs_data = {};
        obs_cyc  = {};
        @(negedge clk);
        check("abort_rel_in_ready", in_ready, 1);
        img_hdr(1);
        img_word(32'hDEAD_BEEF);
        if (CSUM_EN) img_word(32'd0 - 32'hDEAD_BEEF);
        run_image("reload", 1'b0, -1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        apply_reset();
        img_hdr(2);
        img_word(32'h0000_0001);
        img_word(32'h0000_0002);
        img_word(32'hFFFF_FFFD);
        run_image("csum_good", 1'b0, -1, 1'b0);
        apply_reset();
        img_hdr(2);
        img_word(32'h0000_0001);
        img_word(32'h0000_0002);
        img_word(32'hFFFF_FFFE);
        run_image("csum_bad", 1'b0, -1, 1'b0);
`endif

        // Randomized images, sizes, gaps and (when present) checksum corruption.
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            bad = $urandom_range(0, 2);
            build_random($urandom_range(1, 6), bad == 0);
            run_image("rand", $urandom_range(0, 1) == 1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
